// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// A fetch entry carries the instruction together with its PC and PC+4.
package fetch_pkg;

    localparam int          FETCH_AW       = 32;
    localparam int          FETCH_DW       = 32;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [FETCH_AW-1:0] pc;
        logic [FETCH_DW-1:0] instr;
        logic [FETCH_AW-1:0] pc_plus4;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch entries with push, pop and flush.
// Flush only clears pointers and count; stale storage stays visible on the head.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [ENTRY_W-1:0] i_wdata,
    output logic [ENTRY_W-1:0] o_rdata,
    output logic [CW-1:0]      o_count
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational memory
// into a prefetch FIFO and hands entries to decode; redirects flush everything.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = FETCH_RESET_PC,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_instr_o,
    output logic [ADDR_WIDTH-1:0] out_pc_o,
    output logic [ADDR_WIDTH-1:0] out_pc_plus4_o
);

    localparam int            CW         = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;
    logic [CW-1:0]         w_count;
    logic                  w_pop;
    logic                  w_push;
    fetch_entry_t          w_wr_entry;
    fetch_entry_t          w_rd_entry;

    assign w_pc_plus4    = r_pc + ADDR_WIDTH'(4);
    assign w_redirect_pc = redirect_pc_i & ~ADDR_WIDTH'(3);

    // Redirect masks valid so decode never consumes an entry being flushed.
    assign out_valid_o = (w_count != '0) && !redirect_i;
    assign w_pop       = out_valid_o && out_ready_i;
    assign w_push      = !redirect_i && ((w_count < FULL_COUNT) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_i) begin
            r_pc <= w_redirect_pc;
        end else if (w_push) begin
            r_pc <= w_pc_plus4;
        end
    end

    always_comb begin
        w_wr_entry          = '0;
        w_wr_entry.pc       = r_pc;
        w_wr_entry.instr    = imem_rdata_i;
        w_wr_entry.pc_plus4 = w_pc_plus4;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .i_wdata (w_wr_entry),
        .o_rdata (w_rd_entry),
        .o_count (w_count)
    );

    assign imem_addr_o    = r_pc;
    assign out_instr_o    = w_rd_entry.instr;
    assign out_pc_o       = w_rd_entry.pc;
    assign out_pc_plus4_o = w_rd_entry.pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-level reference model checked every
// cycle, plus directed literal checks; a second instance covers PC wrap-around.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic [31:0] imem_addr, imem_rdata;
    logic        valid;
    logic [31:0] instr, opc, opc4;

    logic        rst_n_w;
    logic        w_redirect    = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_ready       = 1'b1;
    logic [31:0] w_addr, w_rdata;
    logic        w_valid;
    logic [31:0] w_instr, w_pc, w_pc4;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            32'h8:   return 32'h0020_81B3;
            default: return NOP_INSTR ^ {a[19:0], 12'h000};
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign w_rdata    = mem_word(w_addr);

    fetch_unit u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr_o    (imem_addr),
        .imem_rdata_i   (imem_rdata),
        .redirect_i     (redirect),
        .redirect_pc_i  (redirect_pc),
        .out_valid_o    (valid),
        .out_ready_i    (ready),
        .out_instr_o    (instr),
        .out_pc_o       (opc),
        .out_pc_plus4_o (opc4)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_n_w),
        .imem_addr_o    (w_addr),
        .imem_rdata_i   (w_rdata),
        .redirect_i     (w_redirect),
        .redirect_pc_i  (w_redirect_pc),
        .out_valid_o    (w_valid),
        .out_ready_i    (w_ready),
        .out_instr_o    (w_instr),
        .out_pc_o       (w_pc),
        .out_pc_plus4_o (w_pc4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an ordered list of fetched entries and the next fetch PC.
    fetch_entry_t mq[$];
    logic [31:0]  mpc;

    initial begin
        logic exp_v, pop, push;
        fetch_entry_t e;
        mpc = 32'h0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (!rst_n) begin
                check("rst_valid", {31'b0, valid}, 32'h0);
                check("rst_addr", imem_addr, 32'h0);
                check("rst_instr", instr, 32'h0);
                check("rst_pc", opc, 32'h0);
                check("rst_pc4", opc4, 32'h0);
                mq.delete();
                mpc = 32'h0;
            end else begin
                exp_v = (mq.size() != 0) && !redirect;
                check("model_valid", {31'b0, valid}, {31'b0, exp_v});
                check("model_addr", imem_addr, mpc);
                if (exp_v) begin
                    check("model_pc", opc, mq[0].pc);
                    check("model_instr", instr, mq[0].instr);
                    check("model_pc4", opc4, mq[0].pc_plus4);
                end
                if (redirect) begin
                    mq.delete();
                    mpc = redirect_pc & 32'hFFFF_FFFC;
                end else begin
                    pop  = exp_v && ready;
                    push = (mq.size() < 2) || pop;
                    if (pop) void'(mq.pop_front());
                    if (push) begin
                        e.pc       = mpc;
                        e.instr    = mem_word(mpc);
                        e.pc_plus4 = mpc + 32'd4;
                        mq.push_back(e);
                        mpc = mpc + 32'd4;
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; rst_n_w = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b0;
        step(); step();
        check("reset_valid", {31'b0, valid}, 32'h0);
        check("reset_addr", imem_addr, 32'h0);
        check("reset_instr", instr, 32'h0);
        check("wrap_reset_addr", w_addr, 32'hFFFF_FFF8);

        // Free run
        rst_n = 1'b1; ready = 1'b1;
        check("first_cycle_valid", {31'b0, valid}, 32'h0);
        step();
        check("free_valid", {31'b0, valid}, 32'h1);
        check("free_pc0", opc, 32'h0);
        check("free_instr0", instr, 32'h0050_0093);
        check("free_pc4_0", opc4, 32'h4);
        step();
        check("free_pc1", opc, 32'h4);
        check("free_instr1", instr, 32'h00A0_0113);
        check("free_pc4_1", opc4, 32'h8);
        step();
        check("free_pc2", opc, 32'h8);
        check("free_instr2", instr, 32'h0020_81B3);
        check("free_pc4_2", opc4, 32'hC);

        // Backpressure from a fresh reset
        rst_n = 1'b0; ready = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (5) step();
        check("bp_addr_hold", imem_addr, 32'h8);
        check("bp_pc_hold", opc, 32'h0);
        check("bp_valid", {31'b0, valid}, 32'h1);
        ready = 1'b1;
        #1;
        check("bp_release_pc0", opc, 32'h0);
        step(); check("bp_pc1", opc, 32'h4);
        step(); check("bp_pc2", opc, 32'h8);
        step(); check("bp_pc3", opc, 32'hC);

        // Redirect with ready high
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        check("redir_valid_low", {31'b0, valid}, 32'h0);
        step();
        redirect = 1'b0;
        check("redir_addr", imem_addr, 32'h100);
        check("redir_empty", {31'b0, valid}, 32'h0);
        step();
        check("redir_valid", {31'b0, valid}, 32'h1);
        check("redir_pc", opc, 32'h100);
        check("redir_instr", instr, NOP_INSTR ^ 32'h0010_0000);

        // Misaligned redirect while full and stalled
        ready = 1'b0;
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        check("mis_addr", imem_addr, 32'h200);
        check("mis_empty", {31'b0, valid}, 32'h0);
        step();
        check("mis_pc", opc, 32'h200);
        check("mis_pc4", opc4, 32'h204);

        // Back-to-back redirects: last one wins
        ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h300;
        step();
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        check("b2b_addr", imem_addr, 32'h40);
        step();
        check("b2b_pc", opc, 32'h40);

        // Asynchronous reset mid-stream
        step();
        check("async_pre_valid", {31'b0, valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'b0, valid}, 32'h0);
        check("async_addr", imem_addr, 32'h0);
        check("async_pc", opc, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_pc", opc, 32'h0);

        // PC wrap-around on the second instance
        rst_n_w = 1'b1;
        step();
        check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        check("wrap_pc4_0", w_pc4, 32'hFFFF_FFFC);
        step();
        check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        check("wrap_pc4_1", w_pc4, 32'h0000_0000);
        step();
        check("wrap_pc2", w_pc, 32'h0000_0000);
        check("wrap_instr2", w_instr, 32'h0050_0093);
        check("wrap_valid", {31'b0, w_valid}, 32'h1);

        done = 1'b1;
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
